sample_byte_packer: RTL and testbench

Downstream of the SRAM read path and upstream of the UART transmitter in the logic analyzer. The block takes 32-bit sample words with a per-byte keep mask (channel-group enables) and serializes only the enabled bytes, lowest lane first, onto a byte-wide valid/ready stream. It also reports readout completion and a count of bytes sent, so the host dump contains exactly the enabled channel groups.

---
 rtl/la_pkg.sv | 12 +
 rtl/sample_byte_packer_if.sv | 28 ++
 rtl/lane_select.sv | 24 ++
 rtl/sample_byte_packer.sv | 135 +++++++++++++
 tb/tb_sample_byte_packer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: packer FSM states and the byte-lane width.
package la_pkg;

   localparam int LANE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      FIN  = 2'd2
   } packer_state_t;

endpackage

// File: rtl/sample_byte_packer_if.sv
// Word-in / byte-out stream bundle for the sample byte packer.
interface sample_byte_packer_if
   import la_pkg::*;
#(
   parameter int DW = 32
);
   localparam int KW = DW / LANE_W;

   logic              word_valid;
   logic              word_ready;
   logic [DW-1:0]     word_data;
   logic [KW-1:0]     word_keep;
   logic              word_last;
   logic              byte_valid;
   logic              byte_ready;
   logic [LANE_W-1:0] byte_data;

   modport master (
      output word_valid, word_data, word_keep, word_last, byte_ready,
      input  word_ready, byte_valid, byte_data
   );

   modport slave (
      input  word_valid, word_data, word_keep, word_last, byte_ready,
      output word_ready, byte_valid, byte_data
   );

endinterface

// File: rtl/lane_select.sv
// Lowest-set-bit priority encoder over the byte-lane mask.
module lane_select #(
   parameter  int KW = 4,
   localparam int IW = (KW > 1) ? $clog2(KW) : 1
) (
   input  logic [KW-1:0] mask,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Scan from the top so the lowest set lane is the last one written.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int k = KW - 1; k >= 0; k--) begin
         if (mask[k]) begin
            idx = IW'(k);
            any = 1'b1;
         end else begin
         end
      end
   end

endmodule

// File: rtl/sample_byte_packer.sv
// Serializes the enabled byte lanes of each sample word, lowest lane first,
// and reports readout completion plus a running byte count.
module sample_byte_packer
   import la_pkg::*;
#(
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   sample_byte_packer_if.slave  bus,
   output logic                 busy,
   output logic                 done,
   output logic [CW-1:0]        byte_count
);

   localparam int KW = DW / LANE_W;
   localparam int IW = (KW > 1) ? $clog2(KW) : 1;
   localparam logic [KW-1:0] LANE_ONE = KW'(1);

   packer_state_t     state_r, state_s;
   logic [DW-1:0]     data_r, data_s;
   logic [KW-1:0]     mask_r, mask_s;
   logic              last_r, last_s;
   logic [CW-1:0]     count_r;
   logic              word_ready_r, byte_valid_r, busy_r, done_r;
   logic [LANE_W-1:0] byte_data_r, lane_s;
   logic [IW-1:0]     cur_idx_s, nxt_idx_s;
   logic              cur_any_s, nxt_any_s;
   logic              word_hs_s, byte_hs_s;

   assign word_hs_s = bus.word_valid & word_ready_r;
   assign byte_hs_s = byte_valid_r & bus.byte_ready;

   // Current mask picks the lane to retire; next mask picks the byte to present.
   lane_select #(.KW(KW)) u_cur_sel (.mask(mask_r), .idx(cur_idx_s), .any(cur_any_s));
   lane_select #(.KW(KW)) u_nxt_sel (.mask(mask_s), .idx(nxt_idx_s), .any(nxt_any_s));

   // Next-state, next-word registers and the lane to present next.
   always_comb begin
      state_s = state_r;
      data_s  = data_r;
      mask_s  = mask_r;
      last_s  = last_r;
      lane_s  = '0;
      case (state_r)
         IDLE: begin
            if (word_hs_s) begin
               data_s  = bus.word_data;
               mask_s  = bus.word_keep;
               last_s  = bus.word_last;
               state_s = (bus.word_keep != '0) ? SEND : FIN;
            end else begin
               state_s = IDLE;
            end
         end
         SEND: begin
            if (!cur_any_s) begin
               state_s = FIN;
            end else if (byte_hs_s) begin
               mask_s  = mask_r & ~(LANE_ONE << cur_idx_s);
               state_s = (mask_s == '0) ? FIN : SEND;
            end else begin
               state_s = SEND;
            end
         end
         FIN: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
            mask_s  = '0;
         end
      endcase
      for (int k = 0; k < KW; k++) begin
         if (nxt_any_s && (nxt_idx_s == IW'(k))) begin
            lane_s = data_s[k*LANE_W +: LANE_W];
         end else begin
         end
      end
   end

   // FSM state and captured word.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_r <= IDLE;
         data_r  <= '0;
         mask_r  <= '0;
         last_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         data_r  <= data_s;
         mask_r  <= mask_s;
         last_r  <= last_s;
      end
   end

   // Outputs are registered from the upcoming state so they line up with it.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         word_ready_r <= 1'b0;
         byte_valid_r <= 1'b0;
         byte_data_r  <= '0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         word_ready_r <= (state_s == IDLE);
         byte_valid_r <= (state_s == SEND);
         byte_data_r  <= lane_s;
         busy_r       <= (state_s != IDLE);
         done_r       <= (state_s == FIN) & last_s;
      end
   end

   // Byte counter; the end-of-readout clear wins over any handshake.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         count_r <= '0;
      end else if ((state_r == FIN) && last_r) begin
         count_r <= '0;
      end else if (byte_hs_s) begin
         count_r <= count_r + CW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign bus.word_ready = word_ready_r;
   assign bus.byte_valid = byte_valid_r;
   assign bus.byte_data  = byte_data_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign byte_count     = count_r;

endmodule

// File: tb/tb_sample_byte_packer.sv
// Directed self-checking bench for sample_byte_packer.
module tb_sample_byte_packer;

   // Narrow counter so the wrap point is reachable in a short run.
   localparam int TB_CW = 10;

   logic             sys_clk = 1'b0;
   logic             sys_rst = 1'b0;
   logic             busy, done;
   logic [TB_CW-1:0] byte_count;
   int               total = 0;
   int               bad   = 0;

   sample_byte_packer_if #(.DW(32)) bus ();

   sample_byte_packer #(.DW(32), .CW(TB_CW)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .byte_count (byte_count)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic put_word(input logic [31:0] d, input logic [3:0] k, input logic l);
      int n;
      n = 0;
      while (!bus.word_ready && n < 20) begin
         @(negedge sys_clk);
         n++;
      end
      chk("word_ready_wait", 32'(bus.word_ready), 32'h1);
      bus.word_valid = 1'b1;
      bus.word_data  = d;
      bus.word_keep  = k;
      bus.word_last  = l;
      @(posedge sys_clk);
      #1 bus.word_valid = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_word_ready"}, 32'(bus.word_ready), 32'h0);
      chk({tag, "_byte_valid"}, 32'(bus.byte_valid), 32'h0);
      chk({tag, "_byte_data"},  32'(bus.byte_data),  32'h0);
      chk({tag, "_busy"},       32'(busy),           32'h0);
      chk({tag, "_done"},       32'(done),           32'h0);
      chk({tag, "_count"},      32'(byte_count),     32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] fk [4];
      fk[0] = 8'h11; fk[1] = 8'h22; fk[2] = 8'h33; fk[3] = 8'h44;
      bus.word_valid = 1'b0;
      bus.word_data  = 32'h0;
      bus.word_keep  = 4'h0;
      bus.word_last  = 1'b0;
      bus.byte_ready = 1'b0;

      // Reset state.
      #2 sys_rst = 1'b1;
      @(negedge sys_clk);
      chk_all_zero("reset");
      sys_rst = 1'b0;
      @(negedge sys_clk);
      chk("post_reset_word_ready", 32'(bus.word_ready), 32'h1);

      // Full keep, last word.
      bus.byte_ready = 1'b1;
      put_word(32'h44332211, 4'hF, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge sys_clk);
         chk("full_valid", 32'(bus.byte_valid), 32'h1);
         chk("full_data",  32'(bus.byte_data),  32'(fk[i]));
         chk("full_count", 32'(byte_count),     32'(i));
      end
      @(negedge sys_clk);
      chk("full_fin_done",  32'(done),           32'h1);
      chk("full_fin_valid", 32'(bus.byte_valid), 32'h0);
      chk("full_fin_count", 32'(byte_count),     32'h4);
      chk("full_fin_wrdy",  32'(bus.word_ready), 32'h0);
      @(negedge sys_clk);
      chk("full_end_done",  32'(done),           32'h0);
      chk("full_end_count", 32'(byte_count),     32'h0);
      chk("full_end_wrdy",  32'(bus.word_ready), 32'h1);
      chk("full_end_busy",  32'(busy),           32'h0);

      // Sparse keep, not last.
      put_word(32'hDDCCBBAA, 4'b1010, 1'b0);
      @(negedge sys_clk);
      chk("sparse_valid0", 32'(bus.byte_valid), 32'h1);
      chk("sparse_data0",  32'(bus.byte_data),  32'hBB);
      @(negedge sys_clk);
      chk("sparse_data1",  32'(bus.byte_data),  32'hDD);
      chk("sparse_count1", 32'(byte_count),     32'h1);
      @(negedge sys_clk);
      chk("sparse_fin_valid", 32'(bus.byte_valid), 32'h0);
      chk("sparse_fin_done",  32'(done),           32'h0);
      chk("sparse_fin_busy",  32'(busy),           32'h1);
      chk("sparse_fin_count", 32'(byte_count),     32'h2);
      @(negedge sys_clk);
      chk("sparse_end_wrdy",  32'(bus.word_ready), 32'h1);
      chk("sparse_end_count", 32'(byte_count),     32'h2);

      // Zero keep, last word: only done, and the count clears.
      put_word(32'h12345678, 4'h0, 1'b1);
      @(negedge sys_clk);
      chk("zero_valid", 32'(bus.byte_valid), 32'h0);
      chk("zero_done",  32'(done),           32'h1);
      chk("zero_busy",  32'(busy),           32'h1);
      chk("zero_wrdy",  32'(bus.word_ready), 32'h0);
      @(negedge sys_clk);
      chk("zero_end_wrdy",  32'(bus.word_ready), 32'h1);
      chk("zero_end_done",  32'(done),           32'h0);
      chk("zero_end_count", 32'(byte_count),     32'h0);

      // Backpressure on the third byte.
      put_word(32'h44332211, 4'hF, 1'b1);
      @(negedge sys_clk);
      chk("bp_data0", 32'(bus.byte_data), 32'h11);
      @(negedge sys_clk);
      chk("bp_data1", 32'(bus.byte_data), 32'h22);
      @(negedge sys_clk);
      chk("bp_data2", 32'(bus.byte_data), 32'h33);
      bus.byte_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge sys_clk);
         chk("bp_hold_valid", 32'(bus.byte_valid), 32'h1);
         chk("bp_hold_data",  32'(bus.byte_data),  32'h33);
         chk("bp_hold_count", 32'(byte_count),     32'h2);
      end
      bus.byte_ready = 1'b1;
      @(negedge sys_clk);
      chk("bp_data3",  32'(bus.byte_data), 32'h44);
      chk("bp_count3", 32'(byte_count),    32'h3);
      @(negedge sys_clk);
      chk("bp_fin_done",  32'(done),       32'h1);
      chk("bp_fin_count", 32'(byte_count), 32'h4);
      @(negedge sys_clk);
      chk("bp_end_count", 32'(byte_count),     32'h0);
      chk("bp_end_wrdy",  32'(bus.word_ready), 32'h1);

      // Reset in the middle of a word.
      put_word(32'h44332211, 4'hF, 1'b0);
      @(negedge sys_clk);
      chk("rst_mid_data0", 32'(bus.byte_data), 32'h11);
      @(negedge sys_clk);
      chk("rst_mid_count1", 32'(byte_count), 32'h1);
      sys_rst = 1'b1;
      #1;
      chk_all_zero("rst_mid");
      @(negedge sys_clk);
      sys_rst = 1'b0;
      put_word(32'hDDCCBBAA, 4'hF, 1'b1);
      @(negedge sys_clk);
      chk("rst_new_data0",  32'(bus.byte_data), 32'hAA);
      chk("rst_new_count0", 32'(byte_count),    32'h0);
      @(negedge sys_clk);
      chk("rst_new_data1",  32'(bus.byte_data), 32'hBB);
      chk("rst_new_count1", 32'(byte_count),    32'h1);

      // Counter wrap: 257 full-keep words, never last.
      for (int w = 0; w < 257; w++) begin
         put_word(32'h44332211, 4'hF, 1'b0);
         repeat (4) @(negedge sys_clk);
         if (w == 255) begin
            chk("wrap_max", 32'(byte_count), 32'h3FF);
         end else begin
         end
         @(negedge sys_clk);
         if (w == 255) begin
            chk("wrap_zero", 32'(byte_count), 32'h0);
         end else begin
         end
      end
      @(negedge sys_clk);
      chk("wrap_end_count", 32'(byte_count),     32'h4);
      chk("wrap_end_wrdy",  32'(bus.word_ready), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
